// File: rtl/add_pipe_pkg.sv
// Shared types and constants for the add_pipe block.
package add_pipe_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_1    = 2'd1,
    S_11   = 2'd2
  } det_state_t;

  // Increment that sticks at the all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; head entry is read combinationally.
module sync_fifo #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_fire, rd_fire;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr_q];

  // Next-state for pointers (power-of-two depth, so they wrap naturally) and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/add_pipe.sv
// Adder stage feeding a result FIFO, with carry counter and 1,1,0 carry-pattern detector.
module add_pipe
  import add_pipe_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W:0]       sum,
  output logic [CNT_W-1:0] carry_cnt,
  output logic [CNT_W-1:0] pat_cnt,
  output logic             pat_hit
);

  logic [W:0]       add_res;
  logic             carry;
  logic             accept;
  logic             fifo_full, fifo_empty;
  logic [W:0]       head;
  logic             run_q;
  det_state_t       state_q;
  logic [CNT_W-1:0] carry_cnt_q, pat_cnt_q;
  logic             pat_hit_q;

  assign add_res   = {1'b0, a} + {1'b0, b};
  assign carry     = add_res[W];
  // run_q delays in_ready until rst_n has been sampled high once.
  assign in_ready  = rst_n && run_q && !fifo_full;
  assign out_valid = rst_n && !fifo_empty;
  assign sum       = out_valid ? head : '0;
  assign accept    = in_valid && in_ready;

  assign carry_cnt = carry_cnt_q;
  assign pat_cnt   = pat_cnt_q;
  assign pat_hit   = pat_hit_q;

  sync_fifo #(
    .WIDTH (W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept),
    .wr_data (add_res),
    .rd_en   (out_valid && out_ready),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Marks that reset has been released and sampled.
  always_ff @(posedge clk) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  // Carry counter and pattern detector; both advance only on accepted pairs.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state_q     <= S_IDLE;
      carry_cnt_q <= '0;
      pat_cnt_q   <= '0;
      pat_hit_q   <= 1'b0;
    end else begin
      pat_hit_q <= 1'b0;
      if (accept) begin
        if (carry) carry_cnt_q <= sat_inc(carry_cnt_q);
        case (state_q)
          S_IDLE:  state_q <= carry ? S_1 : S_IDLE;
          S_1:     state_q <= carry ? S_11 : S_IDLE;
          S_11: begin
            if (carry) begin
              state_q <= S_11;
            end else begin
              state_q   <= S_IDLE;
              pat_hit_q <= 1'b1;
              pat_cnt_q <= pat_cnt_q + 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_add_pipe.sv
// Directed plus random bench for add_pipe against a queue-based reference model.
module tb_add_pipe;

  localparam int unsigned W     = 4;
  localparam int unsigned DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst_n, clr, in_valid, in_ready, out_valid, out_ready, pat_hit;
  logic [W-1:0] a, b;
  logic [W:0]   sum;
  logic [7:0]   carry_cnt, pat_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model state
  logic [W:0] mq[$];
  bit         m_run = 0;
  int         m_ccnt = 0, m_pcnt = 0;
  bit         m_phit = 0;
  bit [1:0]   m_last2 = 2'b00;
  int         m_hn = 0;
  bit         chk_en = 0;

  always #5 clk = ~clk;

  add_pipe #(.W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_cnt (carry_cnt),
    .pat_cnt   (pat_cnt),
    .pat_hit   (pat_hit)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, compare mid-cycle, advance model, cross the edge.
  task automatic cyc(input bit rn, input bit cl, input bit v,
                     input logic [W-1:0] aa, input logic [W-1:0] bb, input bit ordy);
    bit         e_ir, e_ov, acc, del, c, hit;
    logic [W:0] e_sum;
    int         s;
    rst_n = rn; clr = cl; in_valid = v; a = aa; b = bb; out_ready = ordy;
    #3;
    e_ir  = rn && m_run && (mq.size() < DEPTH);
    e_ov  = rn && (mq.size() != 0);
    e_sum = e_ov ? mq[0] : '0;
    if (chk_en) begin
      chk("in_ready",  in_ready,  e_ir);
      chk("out_valid", out_valid, e_ov);
      chk("sum",       sum,       e_sum);
      chk("carry_cnt", carry_cnt, m_ccnt);
      chk("pat_cnt",   pat_cnt,   m_pcnt);
      chk("pat_hit",   pat_hit,   m_phit);
    end
    if (!rn) begin
      mq.delete();
      m_run = 0; m_ccnt = 0; m_pcnt = 0; m_phit = 0; m_hn = 0; m_last2 = 2'b00;
      chk_en = 1;
    end else begin
      m_run = 1;
      acc = v && e_ir;
      del = e_ov && ordy;
      s = int'(aa) + int'(bb);
      if (del) void'(mq.pop_front());
      if (acc) mq.push_back((W+1)'(s));
      if (cl) begin
        m_ccnt = 0; m_pcnt = 0; m_phit = 0; m_hn = 0; m_last2 = 2'b00;
      end else begin
        m_phit = 0;
        if (acc) begin
          c = (s >= (1 << W));
          if (c && m_ccnt < 255) m_ccnt++;
          hit = !c && (m_hn >= 2) && (m_last2 == 2'b11);
          if (hit) begin
            m_phit = 1;
            m_pcnt = (m_pcnt + 1) % 256;
          end
          m_last2 = {m_last2[0], c};
          if (m_hn < 2) m_hn++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; clr = 0; in_valid = 0; a = '0; b = '0; out_ready = 0;

    // Reset and release
    repeat (3) cyc(0, 0, 0, 4'h0, 4'h0, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_carry_cnt", carry_cnt, 0);
    cyc(1, 0, 1, 4'h3, 4'h3, 1);
    chk("rst_in_ready_rise", in_ready, 1);

    // F+1 -> 0x10 next cycle
    cyc(1, 0, 1, 4'hF, 4'h1, 1);
    chk("req037_valid", out_valid, 1);
    chk("req037_sum", sum, 5'h10);
    chk("req037_ccnt", carry_cnt, 1);
    cyc(1, 0, 0, 4'h0, 4'h0, 1);

    // Backpressure: two accepted, third refused, then ordered delivery
    cyc(1, 0, 1, 4'h1, 4'h1, 0);
    cyc(1, 0, 1, 4'h2, 4'h2, 0);
    chk("req038_full", in_ready, 0);
    cyc(1, 0, 1, 4'h3, 4'h3, 0);
    chk("req038_hold", sum, 5'h02);
    cyc(1, 0, 1, 4'h3, 4'h3, 1);
    chk("req038_second", sum, 5'h04);
    cyc(1, 0, 1, 4'h3, 4'h3, 1);
    chk("req038_third", sum, 5'h06);
    cyc(1, 0, 0, 4'h0, 4'h0, 1);

    // Pattern 1,1,0 then 1,1,1,0
    cyc(1, 0, 1, 4'hF, 4'h1, 1);
    cyc(1, 0, 1, 4'hF, 4'hF, 1);
    cyc(1, 0, 1, 4'h1, 4'h1, 1);
    chk("req039_hit", pat_hit, 1);
    chk("req039_pcnt", pat_cnt, 1);
    cyc(1, 0, 0, 4'h0, 4'h0, 1);
    chk("req039_pulse", pat_hit, 0);
    cyc(1, 0, 1, 4'hF, 4'h1, 1);
    cyc(1, 0, 1, 4'hF, 4'h1, 1);
    cyc(1, 0, 1, 4'hF, 4'h1, 1);
    cyc(1, 0, 1, 4'h1, 4'h1, 1);
    cyc(1, 0, 0, 4'h0, 4'h0, 1);
    chk("req039_overlap", pat_cnt, 2);

    // Saturation and wrap
    for (int i = 0; i < 300; i++) cyc(1, 0, 1, 4'h8, 4'h8, 1);
    chk("req040_sat", carry_cnt, 255);
    cyc(1, 1, 0, 4'h0, 4'h0, 1);
    for (int i = 0; i < 256; i++) begin
      cyc(1, 0, 1, 4'hF, 4'h1, 1);
      cyc(1, 0, 1, 4'hF, 4'h1, 1);
      cyc(1, 0, 1, 4'h0, 4'h1, 1);
    end
    chk("req040_wrap", pat_cnt, 0);
    cyc(1, 0, 0, 4'h0, 4'h0, 1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cyc(1, ($urandom_range(15) == 0), 1'($urandom), W'($urandom), W'($urandom), 1'($urandom));

    // Reset with a full buffer
    cyc(1, 0, 0, 4'h0, 4'h0, 1);
    cyc(1, 0, 0, 4'h0, 4'h0, 1);
    repeat (3) cyc(1, 0, 1, 4'h7, 4'h9, 0);
    cyc(0, 0, 1, 4'h7, 4'h9, 1);
    chk("req041_valid", out_valid, 0);
    chk("req041_ccnt", carry_cnt, 0);
    chk("req041_sum", sum, 0);
    repeat (3) cyc(1, 0, 0, 4'h0, 4'h0, 1);

    // clr with a concurrent carry pair
    cyc(1, 0, 1, 4'hF, 4'h1, 1);
    cyc(1, 0, 1, 4'hF, 4'h1, 1);
    cyc(1, 1, 1, 4'hF, 4'hF, 1);
    chk("req042_sum", sum, 5'h1E);
    chk("req042_ccnt", carry_cnt, 0);
    cyc(1, 0, 1, 4'h1, 4'h1, 1);
    chk("req042_nohit", pat_hit, 0);
    repeat (2) cyc(1, 0, 0, 4'h0, 4'h0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add_pipe.md
ADD_PIPE -- requirements
Module: add_pipe

Interface
REQ-001 Parameter W, default 4, operand width in bits.
REQ-002 Parameter DEPTH, default 2, result buffer depth in entries (power of two, >= 2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 clr  input  1  synchronous clear of counters and detector; buffer untouched.
REQ-006 in_valid  input  1  operand pair present.
REQ-007 in_ready  output  1  stage can accept an operand pair.
REQ-008 a  input  W  operand A, unsigned.
REQ-009 b  input  W  operand B, unsigned.
REQ-010 out_valid  output  1  buffered result present.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 sum  output  W+1  result at buffer head; MSB is carry.
REQ-013 carry_cnt  output  8  count of accepted pairs producing carry.
REQ-014 pat_hit  output  1  one-cycle pulse on carry pattern 1,1,0.
REQ-015 pat_cnt  output  8  count of pat_hit pulses.

Function
REQ-016 Accept on rising edge with in_valid && in_ready; deliver on rising edge with out_valid && out_ready.
REQ-017 Stored result SHALL be zero-extended a plus zero-extended b, W+1 bits, no truncation (4'hF + 4'h1 = 5'h10).
REQ-018 Buffer SHALL be FIFO of DEPTH entries; results leave in acceptance order.
REQ-019 in_ready SHALL equal (count < DEPTH), combinational from registered count only; no pass-through when full, even if out_ready is high.
REQ-020 out_valid SHALL equal (count != 0); sum SHALL be head entry, held stable while out_valid && !out_ready.
REQ-021 Latency: pair accepted at edge N into empty buffer SHALL appear on sum with out_valid at edge N+1.
REQ-022 Simultaneous accept and deliver with 0 < count < DEPTH: count unchanged, order preserved.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH.
REQ-024 sum SHALL be 0 when out_valid low.
REQ-025 carry_cnt SHALL increment on each accepted pair with carry, saturating at 255.
REQ-026 Detector FSM states S_IDLE, S_1, S_11, advancing only on accepted pairs using that pair's carry c.
REQ-027 Transitions: S_IDLE c=1->S_1, c=0->S_IDLE; S_1 c=1->S_11, c=0->S_IDLE; S_11 c=1->S_11, c=0->S_IDLE with hit.
REQ-028 pat_hit SHALL be registered, high the cycle after the accepting edge of the completing pair, otherwise low; overlapping patterns detected (1,1,1,0 = one hit).
REQ-029 pat_cnt SHALL increment on each hit, wrapping 255->0.
REQ-030 clr SHALL zero carry_cnt, pat_cnt, pat_hit and force S_IDLE next edge; a pair accepted in the clr cycle SHALL still enter the buffer but not update counters or detector.

Reset
REQ-031 rst_n low at a rising edge SHALL empty buffer (count 0, pointers 0), zero carry_cnt and pat_cnt, pat_hit low, detector S_IDLE.
REQ-032 While rst_n low: in_ready 0, out_valid 0, sum 0; handshakes ignored.
REQ-033 Reset mid-operation SHALL discard all buffered results; none delivered after reset release.
REQ-034 in_ready SHALL rise the first cycle after rst_n sampled high.

Structure
REQ-035 Package add_pipe_pkg SHALL hold det_state_t enum (S_IDLE, S_1, S_11) and counter width constant CNT_W = 8.
REQ-036 Buffer SHALL be sub-module sync_fifo (parameters WIDTH, DEPTH; same clk, rst_n).

Verification
REQ-037 Reset then a=4'hF, b=4'h1 accepted, out_ready=1 -> next cycle out_valid=1, sum=5'h10, carry_cnt=1.
REQ-038 out_ready=0, three pairs offered (1+1, 2+2, 3+3) -> first two accepted, in_ready=0 on third; release out_ready -> sums 2, 4, 6 in order.
REQ-039 Carry stream 1,1,0 (F+1, F+F, 1+1) -> single pat_hit one cycle after third acceptance, pat_cnt=1; stream 1,1,1,0 -> one hit.
REQ-040 300 carry pairs back-to-back -> carry_cnt holds 255; 256 patterns -> pat_cnt=0.
REQ-041 Buffer full, rst_n low one cycle -> out_valid=0, counters 0; no stale sum after release.
REQ-042 clr with simultaneous carry pair accepted -> pair delivered with correct sum, carry_cnt=0 afterward, detector S_IDLE.
